control_unit: RTL and testbench

- Main decoder of the single-issue datapath: maps the 4-bit instruction opcode to the datapath control strobes (register file, ALU operand mux, extender, data memory, branch/jump logic).
- Sits between the instruction register and the datapath.
- Outputs are registered: one clock of latency, asynchronous clear to a safe NOP state.
- Reserved opcodes decode to NOP and raise an illegal-opcode flag.

---
 rtl/control_unit.sv | 136 +++++++++++++
 tb/tb_control_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main opcode decoder: maps the 4-bit opcode to datapath control strobes,
// registered for one cycle of latency with an asynchronous clear to NOP.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opCode,
  output logic       Jcont,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       AluSrc,
  output logic       MemToReg,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ExtOp,
  output logic       MemRead,
  output logic [2:0] AluOp,
  output logic       Illegal
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OP_W-1:0] OP_LW    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SW    = 4'b0101;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OP_W-1:0] OP_J     = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLTI  = 4'b1000;

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  typedef struct packed {
    logic               jcont;
    logic               reg_write;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               mem_write;
    logic               branch;
    logic               ext_op;
    logic               mem_read;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Combinational decode; anything not matched falls through to NOP + illegal.
  always_comb begin
    ctrl_d = '0;
    case (opCode)
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      OP_ADDI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.ext_op    = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.ext_op     = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.ext_op    = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.ext_op = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl_d.jcont = 1'b1;
      end
      OP_SLTI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.ext_op    = 1'b1;
        ctrl_d.alu_op    = ALU_SLT;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign Jcont    = ctrl_q.jcont;
  assign RegWrite = ctrl_q.reg_write;
  assign RegDst   = ctrl_q.reg_dst;
  assign AluSrc   = ctrl_q.alu_src;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ExtOp    = ctrl_q.ext_op;
  assign MemRead  = ctrl_q.mem_read;
  assign AluOp    = ctrl_q.alu_op;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control words checked with
// immediate assertions, plus per-cycle invariant checks.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opCode;
  logic       Jcont, RegWrite, RegDst, AluSrc, MemToReg, MemWrite;
  logic       Branch, ExtOp, MemRead, Illegal;
  logic [2:0] AluOp;

  int  checks = 0;
  int  errors = 0;
  bit  done   = 0;

  // Word layout: J RW RD AS MTR MW B EO MR / AluOp / Illegal
  localparam logic [12:0] W_ZERO = 13'b0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [12:0] W_R    = 13'b0_1_1_0_0_0_0_0_0_000_0;
  localparam logic [12:0] W_ADDI = 13'b0_1_0_1_0_0_0_1_0_001_0;
  localparam logic [12:0] W_ANDI = 13'b0_1_0_1_0_0_0_0_0_010_0;
  localparam logic [12:0] W_ORI  = 13'b0_1_0_1_0_0_0_0_0_011_0;
  localparam logic [12:0] W_LW   = 13'b0_1_0_1_1_0_0_1_1_001_0;
  localparam logic [12:0] W_SW   = 13'b0_0_0_1_0_1_0_1_0_001_0;
  localparam logic [12:0] W_BEQ  = 13'b0_0_0_0_0_0_1_1_0_100_0;
  localparam logic [12:0] W_J    = 13'b1_0_0_0_0_0_0_0_0_000_0;
  localparam logic [12:0] W_SLTI = 13'b0_1_0_1_0_0_0_1_0_101_0;
  localparam logic [12:0] W_RSV  = 13'b0_0_0_0_0_0_0_0_0_000_1;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .opCode   (opCode),
    .Jcont    (Jcont),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .AluSrc   (AluSrc),
    .MemToReg (MemToReg),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ExtOp    (ExtOp),
    .MemRead  (MemRead),
    .AluOp    (AluOp),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs_word();
    return {Jcont, RegWrite, RegDst, AluSrc, MemToReg, MemWrite,
            Branch, ExtOp, MemRead, AluOp, Illegal};
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = obs_word();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive an opcode mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [3:0] op);
    @(negedge clk);
    opCode = op;
    @(posedge clk);
    #1;
  endtask

  // Invariants hold on every cycle for every opcode presented.
  always @(negedge clk) begin
    if (!done) begin
      checks++;
      assert (!(MemWrite && RegWrite)) else begin
        errors++;
        $error("FAIL inv_mw_rw observed=%b%b expected=not 11", MemWrite, RegWrite);
      end
      checks++;
      assert (!(Jcont && Branch)) else begin
        errors++;
        $error("FAIL inv_j_br observed=%b%b expected=not 11", Jcont, Branch);
      end
      checks++;
      assert (!MemRead || MemToReg) else begin
        errors++;
        $error("FAIL inv_mr_mtr observed=%b%b expected=not 10", MemRead, MemToReg);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    opCode = 4'b0000;
    #1;
    check("reset_init", W_ZERO);

    @(negedge clk);
    rst = 1'b0;
    step(4'b0111);
    check("j_pre_reset", W_J);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #3;
    rst    = 1'b1;
    opCode = 4'b0100;
    #1;
    check("rst_async", W_ZERO);
    @(posedge clk);
    #1;
    check("rst_hold", W_ZERO);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("lw_after_rst", W_LW);

    step(4'b0000); check("rtype", W_R);
    step(4'b0001); check("addi",  W_ADDI);
    step(4'b0010); check("andi",  W_ANDI);
    step(4'b0011); check("ori",   W_ORI);
    step(4'b0100); check("lw",    W_LW);
    step(4'b0101); check("sw",    W_SW);
    step(4'b0110); check("beq",   W_BEQ);
    step(4'b0111); check("j",     W_J);
    step(4'b1000); check("slti",  W_SLTI);

    for (int op = 9; op < 16; op++) begin
      step(4'(op));
      check($sformatf("rsv_%0d", op), W_RSV);
    end
    step(4'b0000); check("rtype_after_rsv", W_R);

    // Opcode changes between edges must not reach the outputs.
    step(4'b0001); check("glitch_base", W_ADDI);
    opCode = 4'b0101;
    #1;
    check("glitch_sw", W_ADDI);
    opCode = 4'b0001;
    #1;
    check("glitch_back", W_ADDI);
    opCode = 4'b0101;
    @(posedge clk);
    #1;
    check("glitch_next_edge", W_SW);

    step(4'b1111); check("rsv_last", W_RSV);

    @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
